// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access path: size codes, FSM states
// and the load/store opcodes the control unit decodes.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [5:0] LB = 6'd32;
    localparam logic [5:0] LH = 6'd33;
    localparam logic [5:0] LW = 6'd35;
    localparam logic [5:0] SB = 6'd40;
    localparam logic [5:0] SH = 6'd41;
    localparam logic [5:0] SW = 6'd43;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } mau_state_e;

    // Access attributes latched at acceptance; off is already naturally aligned.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic [1:0] off;
    } acc_t;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane steering: size/offset to byte enables and replicated
// store data, and read word to sign-extended load data. Purely combinational.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        be      = 4'b0000;
        st_word = st_data;
        ld_data = ld_word;
        ld_b    = ld_word[{off, 3'b000} +: 8];
        ld_h    = ld_word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << off;
                st_word = {4{st_data[7:0]}};
                ld_data = {{24{ld_b[7]}}, ld_b};
            end
            SZ_HALF: begin
                be      = 4'b0011 << off;
                st_word = {2{st_data[15:0]}};
                ld_data = {{16{ld_h[15]}}, ld_h};
            end
            SZ_WORD: be = 4'b1111;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding data-memory access unit with bus timeout.
// MEM_ALIGN_CHECK_EN: misaligned half/word accesses respond with an error instead of being force-aligned.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        mem_read,
    input  logic              mem_write,
    input  logic [1:0]        store_size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    mau_state_e        state;
    acc_t              acc;
    logic [ADDR_W-3:0] word_addr;
    logic [31:0]       wdata_q;
    logic [7:0]        cnt;
    logic [31:0]       ld_data;

    logic       accept;
    logic [1:0] in_size;
    logic [1:0] in_off;
    logic       misalign;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready & ((mem_read != SZ_NONE) | mem_write);
    // Stall must cover the acceptance cycle itself, before state leaves IDLE.
    assign stall     = accept | (state != IDLE);
    assign in_size   = mem_write ? store_size : mem_read;
    assign misalign  = ((in_size == SZ_HALF) & addr[0]) |
                       ((in_size == SZ_WORD) & (addr[1:0] != 2'b00));

    always_comb begin
        case (in_size)
            SZ_HALF: in_off = {addr[1], 1'b0};
            SZ_WORD: in_off = 2'b00;
            default: in_off = addr[1:0];
        endcase
    end

    assign bus_we   = acc.we;
    assign bus_addr = {word_addr, 2'b00};

    mem_lane_align u_align (
        .size    (acc.size),
        .off     (acc.off),
        .st_data (wdata_q),
        .ld_word (bus_rdata),
        .be      (bus_be),
        .st_word (bus_wdata),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            word_addr <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            bus_req   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rdata     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    acc       <= '{we: mem_write, size: in_size, off: in_off};
                    word_addr <= addr[ADDR_W-1:2];
                    wdata_q   <= wdata;
                    cnt       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                    if (misalign) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rdata     <= '0;
                    end else begin
                        state   <= ISSUE;
                        bus_req <= 1'b1;
                    end
`else
                    state   <= ISSUE;
                    bus_req <= 1'b1;
`endif
                end
                ISSUE: begin
                    if (bus_ack) begin
                        state     <= RESP;
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rdata     <= acc.we ? 32'h0 : ld_data;
                    end else if (cnt == TO_LAST) begin
                        state     <= RESP;
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rdata     <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Only consulted when alignment checking is built in.
    logic unused_misalign;
    assign unused_misalign = misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver with cycle-accurate bus responder,
// a size/offset arithmetic model and a per-cycle compare process.
module tb_mem_access_unit;

    localparam int ADDR_W = 32;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        mem_read = 2'b00;
    logic              mem_write = 1'b0;
    logic [1:0]        store_size = 2'b00;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic              rsp_valid, rsp_err, stall, bus_req, bus_we;
    logic [31:0]       rdata, bus_wdata;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic              bus_ack = 1'b0;
    logic [31:0]       bus_rdata = '0;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .store_size(store_size),
        .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rdata(rdata), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model expectations for the transaction in flight
    logic        exp_active = 1'b0;
    logic        exp_mis = 1'b0;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;
    logic        exp_err;

    // Driver observations
    int          r_cyc, req_first, req_last;
    logic        r_err, stall_c0, stall_ok, idle_after;
    logic [31:0] r_rdata, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int m_off(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 0;
        if (sz == 2'b10) return (a % 4) / 2 * 2;
        return a % 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int o = m_off(sz, a);
        case (sz)
            2'b01: return 4'(1 << o);
            2'b10: return 4'(3 << o);
            2'b11: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b01: return (wd % 256) * 32'h0101_0101;
            2'b10: return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic [31:0] a,
                                            input logic [31:0] w);
        logic [31:0] s = w >> (8 * m_off(sz, a));
        int v;
        case (sz)
            2'b01: begin v = int'(s % 256); if (v >= 128) v -= 256; return 32'(v); end
            2'b10: begin v = int'(s % 65536); if (v >= 32768) v -= 65536; return 32'(v); end
            default: return w;
        endcase
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (sz == 2'b10 && a % 2 != 0) || (sz == 2'b11 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus_req) begin
                    chk("bus_req_legal", {31'b0, exp_active & ~exp_mis}, 32'd1);
                    chk("bus_addr", bus_addr, exp_addr);
                    chk("bus_be", {28'b0, bus_be}, {28'b0, exp_be});
                    chk("bus_we", {31'b0, bus_we}, {31'b0, exp_we});
                    if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
                    chk("stall_during_req", {31'b0, stall}, 32'd1);
                end
                if (rsp_valid) begin
                    chk("rsp_expected", {31'b0, exp_active}, 32'd1);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
                    chk("rdata", rdata, exp_rdata);
                end
            end
        end
    endtask

    task automatic access(input logic [1:0] rd, input logic wr, input logic [1:0] ss,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input int ack_at);
        logic [1:0] sz = wr ? ss : rd;
        @(negedge clk);
        exp_active = 1'b1;
        exp_mis    = m_mis(sz, a);
        exp_we     = wr;
        exp_addr   = a & ~32'h3;
        exp_be     = m_be(sz, a);
        exp_wdata  = m_wdata(sz, wd);
        exp_err    = exp_mis || ack_at < 0;
        exp_rdata  = (exp_err || wr) ? 32'h0 : m_rdata(sz, a, word);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; store_size = ss;
        addr = a; wdata = wd;
        #1;
        stall_c0 = stall;
        r_cyc = -1; req_first = -1; req_last = -1; stall_ok = 1'b1;
        r_err = 1'b0; r_rdata = 'x; cap_be = 'x; cap_addr = 'x; cap_wdata = 'x; cap_we = 1'bx;
        for (int c = 1; c <= 40 && r_cyc < 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0; mem_read = 2'b00; mem_write = 1'b0;
            bus_ack   = (c == ack_at);
            bus_rdata = (c == ack_at) ? word : 32'hDEAD_BEEF;
            #1;
            if (!stall) stall_ok = 1'b0;
            if (bus_req) begin
                if (req_first < 0) req_first = c;
                req_last = c;
                cap_be = bus_be; cap_addr = bus_addr; cap_wdata = bus_wdata; cap_we = bus_we;
            end
            if (rsp_valid) begin r_cyc = c; r_err = rsp_err; r_rdata = rdata; end
        end
        if (r_cyc < 0) chk("rsp_timeout_bound", 32'(r_cyc), 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        idle_after = req_ready & ~stall & ~rsp_valid;
        exp_active = 1'b0;
    endtask

    initial begin
        fork compare_loop(); join_none
        fork begin #500000; $display("FAIL watchdog: got timeout expected finish"); $fatal(1); end join_none

        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_flags", {27'b0, stall, rsp_valid, rsp_err, bus_req, bus_we}, 32'd0);
        chk("rst_data", rdata | bus_addr | bus_wdata | {28'b0, bus_be}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // lw, zero-wait memory
        access(2'b11, 0, 2'b00, 32'h10, 0, 32'h8000_00FF, 1);
        chk("lw_rdata", r_rdata, 32'h8000_00FF);
        chk("lw_be", {28'b0, cap_be}, 32'hF);
        chk("lw_addr", cap_addr, 32'h10);
        chk("lw_rsp_cyc", 32'(r_cyc), 32'd2);
        chk("lw_req_first", 32'(req_first), 32'd1);
        chk("lw_stall", {30'b0, stall_c0, stall_ok}, 32'd3);
        chk("lw_idle_after", {31'b0, idle_after}, 32'd1);

        access(2'b01, 0, 2'b00, 32'h13, 0, 32'h80FF_7F01, 2);
        chk("lb_be", {28'b0, cap_be}, 32'h8);
        chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
        chk("lb_rsp_cyc", 32'(r_cyc), 32'd3);

        access(2'b10, 0, 2'b00, 32'h12, 0, 32'h80FF_7F01, 1);
        chk("lh_be", {28'b0, cap_be}, 32'hC);
        chk("lh_rdata", r_rdata, 32'hFFFF_80FF);

        access(2'b01, 0, 2'b00, 32'h10, 0, 32'h80FF_7F01, 1);
        chk("lb0_rdata", r_rdata, 32'h0000_0001);
        access(2'b10, 0, 2'b00, 32'h10, 0, 32'h80FF_7F01, 4);
        chk("lh0_rdata", r_rdata, 32'h0000_7F01);

        access(2'b00, 1, 2'b01, 32'h21, 32'h0000_00AB, 32'h1234_5678, 3);
        chk("sb_we", {31'b0, cap_we}, 32'd1);
        chk("sb_be", {28'b0, cap_be}, 32'h2);
        chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        chk("sb_addr", cap_addr, 32'h20);
        chk("sb_rdata", r_rdata, 32'h0);

        access(2'b00, 1, 2'b10, 32'h16, 32'h1234_5678, 0, 1);
        chk("sh_be", {28'b0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'h5678_5678);

        // load and store both set: treated as a store
        access(2'b11, 1, 2'b01, 32'h03, 32'h0000_00CD, 32'hFFFF_FFFF, 1);
        chk("ldst_we", {31'b0, cap_we}, 32'd1);
        chk("ldst_be", {28'b0, cap_be}, 32'h8);
        chk("ldst_rdata", r_rdata, 32'h0);

        // timeout, then a late ack is ignored
        access(2'b11, 0, 2'b00, 32'h30, 0, 0, -1);
        chk("to_req_last", 32'(req_last), 32'(TO));
        chk("to_rsp_cyc", 32'(r_cyc), 32'(TO + 1));
        chk("to_err", {31'b0, r_err}, 32'd1);
        @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        @(negedge clk); bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("late_ack_ignored", {30'b0, rsp_valid, req_ready}, 32'd1);
            @(negedge clk);
        end
        access(2'b11, 0, 2'b00, 32'h34, 0, 32'hCAFE_F00D, 2);
        chk("post_to_rdata", r_rdata, 32'hCAFE_F00D);
        chk("post_to_err", {31'b0, r_err}, 32'd0);

        // misaligned word
        access(2'b11, 0, 2'b00, 32'h22, 0, 32'h0BAD_CAFE, 1);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_err", {31'b0, r_err}, 32'd1);
        chk("mis_no_req", 32'(req_first), 32'hFFFF_FFFF);
        chk("mis_rsp_cyc", 32'(r_cyc), 32'd1);
        chk("mis_rdata", r_rdata, 32'h0);
`else
        chk("mis_addr", cap_addr, 32'h20);
        chk("mis_be", {28'b0, cap_be}, 32'hF);
        chk("mis_rdata", r_rdata, 32'h0BAD_CAFE);
        chk("mis_err", {31'b0, r_err}, 32'd0);
`endif

        // request with neither load nor store is not accepted
        @(negedge clk);
        req_valid = 1'b1; mem_read = 2'b00; mem_write = 1'b0; addr = 32'h40;
        #1; chk("noop_stall", {31'b0, stall}, 32'd0);
        @(negedge clk); req_valid = 1'b0;
        #1; chk("noop_idle", {29'b0, bus_req, stall, req_ready}, 32'd1);

        // reset in the middle of a pending access
        @(negedge clk);
        exp_active = 1'b1; exp_mis = 1'b0; exp_we = 1'b0; exp_addr = 32'h40;
        exp_be = 4'hF; exp_err = 1'b0; exp_rdata = 32'h0;
        req_valid = 1'b1; mem_read = 2'b11; addr = 32'h40;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); req_valid = 1'b0; mem_read = 2'b00;
        end
        #1; chk("rst_mid_req_before", {31'b0, bus_req}, 32'd1);
        exp_active = 1'b0;
        rst_n = 1'b0;
        #1; chk("rst_mid_req_drop", {30'b0, bus_req, rsp_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus_ack = (i == 0); bus_rdata = 32'h7777_7777;
            #1; chk("rst_mid_quiet", {29'b0, rsp_valid, bus_req, req_ready}, 32'd1);
        end
        bus_ack = 1'b0;
        access(2'b11, 0, 2'b00, 32'h44, 0, 32'h0102_0304, 1);
        chk("post_rst_rdata", r_rdata, 32'h0102_0304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
